// File: rtl/intc_pkg.sv
// Interrupt controller shared definitions.
// Register map, FSM states and default source count.
package intc_pkg;

  localparam int NSRC_DEF = 6;

  localparam logic [2:0] ADDR_MASK = 3'd0;
  localparam logic [2:0] ADDR_EDGE = 3'd1;
  localparam logic [2:0] ADDR_PEND = 3'd2;
  localparam logic [2:0] ADDR_ISR  = 3'd3;
  localparam logic [2:0] ADDR_VEC  = 3'd4;
  localparam logic [2:0] ADDR_EOI  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder.
// Ports: req (N requests), idx (winning index), valid (any request).
module intc_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [3:0]   idx,
  output logic         valid
);

  // Scan downward so the lowest set index is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller feeding CP0 HWInt.
// Ports: clk, rst (async high), irq_in, we/addr/wdata/rdata
// register bus, int_ack from CPU, hwint one-hot request out.
// Option: define INTC_NESTING_EN to allow preemption in SERVICE.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_in,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            int_ack,
  output logic [NSRC-1:0] hwint
);

  function automatic logic [NSRC-1:0] oh(input logic [3:0] i);
    oh = '0;
    for (int k = 0; k < NSRC; k++) oh[k] = (4'(k) == i);
  endfunction

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] s, s_prev, rise;
  logic [NSRC-1:0] mask, edge_mode, pend, isr;
  logic [NSRC-1:0] clr, cand, oh_vec, isr_pop;
  state_t          state;
  logic [3:0]      vec;
  logic [3:0]      win_idx, isr_idx;
  logic            win_v, isr_v;
  logic            ack, eoi, pend_wr, vec_valid;
  logic            unused_wdata;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_prev;
  assign ack       = (state == ASSERT) && int_ack;
  assign pend_wr   = we && (addr == ADDR_PEND);
  assign eoi       = we && (addr == ADDR_EOI) && isr_v;
  assign oh_vec    = oh(vec);
  assign clr       = (pend_wr ? wdata[NSRC-1:0] : '0)
                   | (ack ? oh_vec : '0);
  assign cand      = pend & mask & ~isr;
  assign isr_pop   = isr & ~oh(isr_idx);
  assign vec_valid = (state == ASSERT) || (state == SERVICE);
  assign unused_wdata = ^wdata[31:NSRC];

  intc_prio_enc #(.N(NSRC)) u_win (
    .req   (cand),
    .idx   (win_idx),
    .valid (win_v)
  );

  intc_prio_enc #(.N(NSRC)) u_isr (
    .req   (isr),
    .idx   (isr_idx),
    .valid (isr_v)
  );

`ifdef INTC_NESTING_EN
  logic [NSRC-1:0] above;
  logic [3:0]      nest_idx;
  logic            nest_v;

  // Only sources strictly above the innermost in-service one.
  always_comb begin
    above = '0;
    for (int k = 0; k < NSRC; k++) above[k] = (4'(k) < isr_idx);
  end

  intc_prio_enc #(.N(NSRC)) u_nest (
    .req   (cand & above),
    .idx   (nest_idx),
    .valid (nest_v)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev    <= '0;
      mask      <= '0;
      edge_mode <= '0;
      pend      <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
      if (we && (addr == ADDR_MASK)) mask <= wdata[NSRC-1:0];
      if (we && (addr == ADDR_EDGE)) edge_mode <= wdata[NSRC-1:0];
      // Edge bits: clear then set, so a same-cycle rise wins.
      pend <= (edge_mode & ((pend & ~clr) | rise))
            | (~edge_mode & s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      isr   <= '0;
      hwint <= '0;
    end else begin
      hwint <= '0;
      unique case (state)
        IDLE: begin
          if (win_v) begin
            state <= ASSERT;
            vec   <= win_idx;
          end
        end
        ASSERT: begin
          if (int_ack) begin
            isr   <= isr | oh_vec;
            state <= SERVICE;
          end else if (~|(pend & mask & oh_vec)) begin
            state <= isr_v ? SERVICE : IDLE;
          end else begin
            hwint <= oh_vec;
          end
        end
        SERVICE: begin
          if (eoi) begin
            isr <= isr_pop;
            if (~|isr_pop) state <= IDLE;
          end
`ifdef INTC_NESTING_EN
          else if (nest_v) begin
            state <= ASSERT;
            vec   <= nest_idx;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == ADDR_MASK: rdata = 32'(mask);
      addr == ADDR_EDGE: rdata = 32'(edge_mode);
      addr == ADDR_PEND: rdata = 32'(pend);
      addr == ADDR_ISR:  rdata = 32'(isr);
      addr == ADDR_VEC:  rdata = {27'b0, vec_valid, vec};
      default:           rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl.
// Register table plus hand-written interrupt sequences.
module tb_int_ctrl;
  import intc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  irq_in = '0;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_ack = 1'b0;
  logic [5:0]  hwint;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  int_ctrl #(.NSRC(6), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_ack (int_ack),
    .hwint   (hwint)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic rchk(input string name, input logic [2:0] a,
                      input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, ADDR_MASK, 32'h0000_003F, ADDR_MASK, 32'h3F};
    tbl[1]  = '{1'b1, ADDR_EDGE, 32'h0000_002A, ADDR_EDGE, 32'h2A};
    tbl[2]  = '{1'b1, ADDR_MASK, 32'hFFFF_FFFF, ADDR_MASK, 32'h3F};
    tbl[3]  = '{1'b0, ADDR_MASK, 32'h0,         ADDR_PEND, 32'h0};
    tbl[4]  = '{1'b1, ADDR_ISR,  32'h0000_003F, ADDR_ISR,  32'h0};
    tbl[5]  = '{1'b1, ADDR_VEC,  32'h0000_001F, ADDR_VEC,  32'h0};
    tbl[6]  = '{1'b1, ADDR_EOI,  32'h0000_0001, ADDR_VEC,  32'h0};
    tbl[7]  = '{1'b0, ADDR_MASK, 32'h0,         ADDR_EOI,  32'h0};
    tbl[8]  = '{1'b0, ADDR_MASK, 32'h0,         3'd6,      32'h0};
    tbl[9]  = '{1'b0, ADDR_MASK, 32'h0,         3'd7,      32'h0};
    tbl[10] = '{1'b1, ADDR_EDGE, 32'h0,         ADDR_EDGE, 32'h0};
    tbl[11] = '{1'b1, ADDR_MASK, 32'h0,         ADDR_MASK, 32'h0};

    // reset state
    wait_n(2);
    chk("rst_hwint", 32'(hwint), 32'h0);
    rchk("rst_mask", ADDR_MASK, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      logic [31:0] d;
      if (tbl[i].we) wr(tbl[i].waddr, tbl[i].wdata);
      rd(tbl[i].raddr, d);
      chk($sformatf("tbl%0d", i), d, tbl[i].exp);
    end

    // edge source 0: latency, ack, EOI
    wr(ADDR_MASK, 32'h3F);
    wr(ADDR_EDGE, 32'h01);
    irq_in = 6'b000001;
    wait_n(4);
    chk("lat_early", 32'(hwint), 32'h0);
    tick();
    chk("lat_hwint", 32'(hwint), 32'h01);
    rchk("lat_vec", ADDR_VEC, 32'h10);
    ack();
    chk("ack_hwint", 32'(hwint), 32'h0);
    rchk("ack_isr", ADDR_ISR, 32'h01);
    rchk("ack_pend", ADDR_PEND, 32'h0);
    rchk("ack_vec", ADDR_VEC, 32'h10);
    wr(ADDR_EOI, 32'h0);
    rchk("eoi_vec", ADDR_VEC, 32'h00);
    rchk("eoi_isr", ADDR_ISR, 32'h0);
    irq_in = '0;
    wait_n(4);

    // sources 3 and 1 together
    wr(ADDR_EDGE, 32'h0);
    irq_in = 6'b001010;
    wait_n(6);
    chk("pri_hwint1", 32'(hwint), 32'h02);
    rchk("pri_vec1", ADDR_VEC, 32'h11);
    ack();
    irq_in = 6'b001000;
    wait_n(4);
    wr(ADDR_EOI, 32'h0);
    wait_n(2);
    chk("pri_hwint3", 32'(hwint), 32'h08);
    rchk("pri_vec3", ADDR_VEC, 32'h13);
    irq_in = '0;
    wait_n(6);
    chk("drop_hwint", 32'(hwint), 32'h0);
    rchk("drop_vec", ADDR_VEC, 32'h03);

    // mask drop while asserting source 2
    irq_in = 6'b000100;
    wait_n(6);
    chk("msk_hwint_on", 32'(hwint), 32'h04);
    rchk("msk_vec_on", ADDR_VEC, 32'h12);
    wr(ADDR_MASK, 32'h3B);
    tick();
    chk("msk_hwint_off", 32'(hwint), 32'h0);
    rchk("msk_vec_off", ADDR_VEC, 32'h02);
    irq_in = '0;
    wait_n(4);
    wr(ADDR_MASK, 32'h3F);

    // source 1 arrives while source 4 in service
    irq_in = 6'b010000;
    wait_n(6);
    chk("svc_hwint4", 32'(hwint), 32'h10);
    ack();
    rchk("svc_isr4", ADDR_ISR, 32'h10);
    irq_in = 6'b010010;
    wait_n(6);
`ifdef INTC_NESTING_EN
    chk("nest_hwint1", 32'(hwint), 32'h02);
    ack();
    rchk("nest_isr", ADDR_ISR, 32'h12);
    irq_in = 6'b010000;
    wait_n(4);
    wr(ADDR_EOI, 32'h0);
    rchk("nest_pop1", ADDR_ISR, 32'h10);
    rchk("nest_vec", ADDR_VEC, 32'h11);
    irq_in = '0;
    wait_n(4);
    wr(ADDR_EOI, 32'h0);
    rchk("nest_pop2", ADDR_ISR, 32'h0);
`else
    chk("nonest_hwint", 32'(hwint), 32'h0);
    rchk("nonest_isr", ADDR_ISR, 32'h10);
    irq_in = 6'b000010;
    wait_n(4);
    wr(ADDR_EOI, 32'h0);
    wait_n(2);
    chk("nonest_hwint1", 32'(hwint), 32'h02);
    irq_in = '0;
    wait_n(6);
`endif
    rchk("svc_end_vec", ADDR_VEC, 32'h01);

    // rise on source 4 coincides with PEND clear
    wr(ADDR_MASK, 32'h0);
    wr(ADDR_EDGE, 32'h10);
    irq_in = 6'b010000;
    wait_n(2);
    wr(ADDR_PEND, 32'h10);
    rchk("race_pend", ADDR_PEND, 32'h10);
    wr(ADDR_PEND, 32'h10);
    rchk("clr_pend", ADDR_PEND, 32'h0);

    // reset in the middle of service
    wr(ADDR_MASK, 32'h3F);
    irq_in = 6'b010100;
    wait_n(6);
    chk("pre_rst_hwint", 32'(hwint), 32'h04);
    ack();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_hwint", 32'(hwint), 32'h0);
    rchk("arst_mask", ADDR_MASK, 32'h0);
    rchk("arst_edge", ADDR_EDGE, 32'h0);
    rchk("arst_pend", ADDR_PEND, 32'h0);
    rchk("arst_isr", ADDR_ISR, 32'h0);
    rchk("arst_vec", ADDR_VEC, 32'h0);
    irq_in = '0;
    wait_n(2);
    rst = 1'b0;
    tick();
    ack();
    tick();
    rchk("idle_ack_vec", ADDR_VEC, 32'h0);
    rchk("idle_ack_isr", ADDR_ISR, 32'h0);
    chk("idle_ack_hwint", 32'(hwint), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 6: number of interrupt sources, equal to the CP0 HWInt width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on irq_in, minimum 2.
REQ-003 SHALL have ports: clk  in  1  clock (reset rst, asynchronous, active-high; clock clk).
REQ-004 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: irq_in  in  NSRC  raw device interrupt lines, asynchronous to clk.
REQ-006 SHALL have ports: we  in  1  register write strobe.
REQ-007 SHALL have ports: addr  in  3  register select: 0 MASK, 1 EDGE, 2 PEND, 3 ISR, 4 VEC, 5 EOI.
REQ-008 SHALL have ports: wdata  in  32  write data.
REQ-009 SHALL have ports: rdata  out  32  combinational read data, zero-extended; unmapped addresses and EOI read 0.
REQ-010 SHALL have ports: int_ack  in  1  one-cycle pulse from the CPU when the interrupt is taken (CP0 EXL set).
REQ-011 SHALL have ports: hwint  out  NSRC  registered one-hot request to CP0 HWInt.

Function
- REQ-012 SHALL sync irq_in through SYNC_STAGES flops; all logic uses the synchronised value s.
- REQ-013 Per source i: EDGE[i]=1 sets PEND[i] on a 0->1 transition of s[i]; EDGE[i]=0 sets PEND[i]=s[i] each cycle (level, not write-clearable).
- REQ-014 Writing PEND with 1 bits clears those edge-mode bits; a set event in the same cycle wins.
- REQ-015 Priority: lower index is higher priority; winner = lowest i with PEND[i] & MASK[i] & ~ISR[i].
- REQ-016 FSM states: IDLE, ASSERT, SERVICE; reset state IDLE.
- REQ-017 IDLE: winner exists -> ASSERT, latching winner into VEC; hwint = onehot(VEC) from the next cycle.
- REQ-018 ASSERT: VEC is frozen; if PEND[VEC] or MASK[VEC] drops before int_ack -> IDLE, hwint 0 the next cycle.
- REQ-019 ASSERT and int_ack: set ISR[VEC]; clear PEND[VEC] if edge mode; -> SERVICE; hwint 0 the next cycle.
- REQ-020 SERVICE: EOI write (any data) clears the highest-priority set ISR bit -> IDLE if ISR becomes 0, else stay in SERVICE.
- REQ-021 int_ack in IDLE or SERVICE is ignored; EOI with ISR=0 is ignored.
- REQ-022 VEC read returns {27'b0, valid, VEC[3:0]}, where valid = (state==ASSERT)|(state==SERVICE).
- REQ-023 Latency: first clk edge sampling an irq_in rise -> hwint high SYNC_STAGES+2 cycles later, given MASK set and IDLE.
- REQ-024 hwint SHALL be one-hot or zero at all times.

Reset
- REQ-025 rst asynchronously clears the sync flops, MASK, EDGE, PEND, ISR, VEC and hwint, and sets the FSM to IDLE.
- REQ-026 rst mid-ASSERT or mid-SERVICE SHALL drop hwint within the same cycle; in-service state is lost.

Configuration
- REQ-027 Macro INTC_NESTING_EN: when defined, the SERVICE state also runs the REQ-015 winner search, restricted to sources of higher priority than the lowest set ISR index.
- REQ-028 With INTC_NESTING_EN, that preempting winner goes to ASSERT; ack stacks an additional ISR bit; EOI pops per REQ-020, returning to SERVICE while ISR is nonzero.
- REQ-029 Without INTC_NESTING_EN, no request is asserted while ISR is nonzero, and ISR holds at most one bit.

Structure
- REQ-030 A shared package intc_pkg SHALL hold the register address constants, the FSM state enum, and the NSRC default.
- REQ-031 A sub-module intc_prio_enc (NSRC-wide lowest-index priority encoder with valid output) SHALL be instantiated for the winner search and the ISR highest/lowest lookups.

Verification
- REQ-032 Bench SHALL run: MASK=0x3F, EDGE=0x01, irq_in[0] rise -> hwint=6'b000001 after 4 cycles; int_ack -> ISR=0x01, PEND[0]=0, hwint=0; EOI -> IDLE.
- REQ-033 Bench SHALL run: PEND sources 3 and 1 simultaneously, MASK=0x3F -> VEC=1, hwint=6'b000010; after ack+EOI -> hwint=6'b001000.
- REQ-034 Bench SHALL run: in ASSERT with VEC=2, write MASK=0x3B -> hwint=0 next cycle, state IDLE.
- REQ-035 Bench SHALL run: in SERVICE with ISR=0x10, source 1 pends -> with INTC_NESTING_EN hwint=6'b000010 then ISR=0x12 after ack; without it hwint stays 0 until EOI.
- REQ-036 Bench SHALL run: edge rise on source 4 in the same cycle as PEND write 0x10 -> PEND[4]=1.
- REQ-037 Bench SHALL run: rst asserted mid-SERVICE -> hwint=0, all registers 0 without a clk edge; int_ack in IDLE -> no state change.
